// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process
// two WIDTH-bit operands LSB-first over WIDTH cycles with a start/busy/done handshake.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-2:0] sreg;
  logic             c;
  logic             c_msb;

  logic             s_bit;
  logic             c_nxt;

  // The single full-adder cell
  assign s_bit = areg[0] ^ breg[0] ^ c;
  assign c_nxt = (areg[0] & breg[0]) | (areg[0] & c) | (breg[0] & c);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      areg      <= '0;
      breg      <= '0;
      sreg      <= '0;
      c         <= 1'b0;
      c_msb     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            areg  <= a;
            breg  <= sub ? ~b : b;
            c     <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          areg <= areg >> 1;
          breg <= breg >> 1;
          sreg <= (WIDTH-1)'({s_bit, sreg} >> 1);
          c    <= c_nxt;
          cnt  <= cnt + CW'(1);
          // Carry into the MSB is kept for the signed-overflow test
          if (cnt == CW'(WIDTH-2)) begin
            c_msb <= c_nxt;
          end
          if (cnt == CW'(WIDTH-1)) begin
            sum       <= {s_bit, sreg};
            carry_out <= c_nxt;
            overflow  <= c_msb ^ c_nxt;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed vector table,
// multi-cycle corner sequences and a back-to-back random sweep via a scoreboard.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
  } res_t;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   done_count = 0;
  int   last_done_cyc = 0;
  bit   have_last = 0;
  bit   sweep = 0;
  res_t q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent reference: widened arithmetic plus sign-rule overflow
  function automatic res_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    res_t r;
    logic [W:0] t;
    if (!s) begin
      t    = {1'b0, x} + {1'b0, y};
      r.co = t[W];
      r.ov = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    end else begin
      t    = {1'b0, x} - {1'b0, y};
      r.co = (x >= y);
      r.ov = (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]);
    end
    r.sum = t[W-1:0];
    return r;
  endfunction

  // Scoreboard: every done pulse pops one expected result
  always @(posedge clk) begin
    #1;
    if (done) begin
      done_count++;
      check("done_busy_low", 32'(busy), 32'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation (cycle %0d)", cyc);
      end else begin
        res_t e;
        e = q.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("carry_out", 32'(carry_out), 32'(e.co));
        check("overflow", 32'(overflow), 32'(e.ov));
      end
      if (sweep && have_last) check("done_spacing", 32'(cyc - last_done_cyc), 32'd10);
      have_last     = sweep;
      last_done_cyc = cyc;
    end
  end

  // Hold start until an IDLE edge accepts it (busy rising), bounded
  task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    logic pb;
    bit   got;
    sub   = s;
    a     = x;
    b     = y;
    start = 1'b1;
    pb    = busy;
    got   = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      if (busy && !pb) got = 1'b1;
      pb = busy;
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no busy rise expected accept within 40 cycles");
    end else begin
      accept_cyc = cyc;
      if (push) q.push_back(model(s, x, y));
    end
  endtask

  // Wait for done, counting busy cycles; checks latency and busy length
  task automatic wait_done_timed();
    int  bc;
    bit  got;
    bc  = 1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      if (done) got = 1'b1;
      else if (busy) bc++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end else begin
      check("latency", 32'(cyc - accept_cyc), 32'(W));
      check("busy_cycles", 32'(bc), 32'(W));
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  vec_t vt[6];

  initial begin
    int dc;
    vt[0] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vt[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vt[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vt[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vt[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vt[5] = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_co", 32'(carry_out), 32'd0);
    check("rst_ov", 32'(overflow), 32'd0);
    reset = 1'b0;

    // Directed table: expected values are literal constants
    for (int i = 0; i < 6; i++) begin
      res_t e;
      issue(vt[i].sub, vt[i].a, vt[i].b, 1'b0);
      e.sum = vt[i].sum;
      e.co  = vt[i].co;
      e.ov  = vt[i].ov;
      q.push_back(e);
      wait_done_timed();
    end

    // Second start mid-run and operand changes must not disturb the operation
    repeat (2) @(posedge clk);
    #1;
    issue(1'b0, 8'h12, 8'h34, 1'b1);
    dc = done_count;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    @(posedge clk);
    #1;
    a     = 8'h55;
    b     = 8'hAA;
    sub   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("single_done", 32'(done_count - dc), 32'd1);
    check("ignored_no_busy", 32'(busy), 32'd0);
    check("hold_sum", 32'(sum), 32'h46);

    // Reset mid-run: aborts, clears result, no done pulse
    issue(1'b0, 8'hFF, 8'hFF, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_sum", 32'(sum), 32'h46);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_co", 32'(carry_out), 32'd0);
    dc = done_count;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_count - dc), 32'd0);
    issue(1'b1, 8'h80, 8'h01, 1'b1);
    wait_done_timed();

    // Back-to-back random sweep
    sweep     = 1'b1;
    have_last = 1'b0;
    for (int i = 0; i < 500; i++) begin
      issue(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'b1);
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'd0);
    sweep = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
